// File: rtl/wam_score.sv
// Whack-a-mole scorer: per-channel toggle debounce, hit/miss qualification
// against the mole mask, and a saturating synchronous BCD score counter.
module wam_score #(
    parameter int N_HOLE  = 8,
    parameter int DB_CNT  = 4,
    parameter int N_DIG   = 3,
    parameter int PENALTY = 0
) (
    input  logic                 clk_19,
    input  logic                 clr,
    input  logic [N_HOLE-1:0]    sw,
    input  logic [N_HOLE-1:0]    holes,
    input  logic                 en,
    output logic [N_HOLE-1:0]    hit,
    output logic                 miss,
    output logic [4*N_DIG-1:0]   score,
    output logic                 sat
);

    localparam logic [3:0] DB_LIM = 4'(DB_CNT);

    logic [N_HOLE-1:0]  r_sw_pre;
    logic [N_HOLE-1:0]  r_holes_q;
    logic [N_HOLE-1:0]  r_tap;
    logic [N_HOLE-1:0]  r_hit;
    logic               r_miss;
    logic [3:0]         r_cnt [N_HOLE];
    logic [4*N_DIG-1:0] r_score;

    logic [N_HOLE-1:0]  w_edg;
    logic [N_HOLE-1:0]  w_tap_next;
    logic [3:0]         w_cnt_next [N_HOLE];
    logic [3:0]         w_pop;
    logic               w_pen;
    logic               w_dec;
    logic [3:0]         w_addend;
    logic [4*N_DIG-1:0] w_add_score;
    logic [4*N_DIG-1:0] w_sub_score;
    logic [4*N_DIG-1:0] w_all9;
    logic               w_add_ovf;
    logic               w_sub_unf;
    logic [4*N_DIG-1:0] w_score_next;

    assign w_edg = sw ^ r_sw_pre;

    // Count 0 is idle; 1..DB_CNT is filtering. Any toggle while filtering
    // below the limit aborts, and the toggle that aborts does not restart.
    genvar gi;
    generate
        for (gi = 0; gi < N_HOLE; gi++) begin : g_db
            assign w_tap_next[gi] = (r_cnt[gi] >= DB_LIM);
            assign w_cnt_next[gi] = (r_cnt[gi] == 4'd0) ? (w_edg[gi] ? 4'd1 : 4'd0) :
                                    ((r_cnt[gi] >= DB_LIM) || w_edg[gi]) ? 4'd0 :
                                    r_cnt[gi] + 4'd1;
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_HOLE; i++) begin
            w_pop = w_pop + {3'd0, r_hit[i]};
        end
    end

    // A miss with no hits is a pure decrement; otherwise it just trims the add.
    assign w_pen    = (PENALTY != 0) && r_miss;
    assign w_dec    = w_pen && (w_pop == 4'd0);
    assign w_addend = w_pop - {3'd0, (w_pen && !w_dec)};

    always_comb begin : p_bcd
        logic [4:0] v_sum;
        logic [3:0] v_dig;
        logic       v_carry;
        logic       v_borrow;
        w_add_score = '0;
        w_sub_score = '0;
        w_all9      = '0;
        v_sum       = '0;
        v_dig       = '0;
        v_carry     = 1'b0;
        v_borrow    = 1'b1;
        for (int d = 0; d < N_DIG; d++) begin
            v_dig = r_score[4*d +: 4];
            v_sum = {1'b0, v_dig} + {4'd0, v_carry} + ((d == 0) ? {1'b0, w_addend} : 5'd0);
            if (v_sum > 5'd9) begin
                v_sum   = v_sum - 5'd10;
                v_carry = 1'b1;
            end else begin
                v_carry = 1'b0;
            end
            w_add_score[4*d +: 4] = v_sum[3:0];
            if (v_borrow && (v_dig == 4'd0)) begin
                w_sub_score[4*d +: 4] = 4'd9;
            end else begin
                w_sub_score[4*d +: 4] = v_dig - {3'd0, v_borrow};
                v_borrow = 1'b0;
            end
            w_all9[4*d +: 4] = 4'd9;
        end
        w_add_ovf = v_carry;
        w_sub_unf = v_borrow;
    end

    // Carry out of the top digit clamps high; borrow out clamps at zero.
    always_comb begin
        w_score_next = r_score;
        if (w_dec) begin
            w_score_next = w_sub_unf ? '0 : w_sub_score;
        end else begin
            w_score_next = w_add_ovf ? w_all9 : w_add_score;
        end
    end

    always_ff @(posedge clk_19 or posedge clr) begin
        if (clr) begin
            r_sw_pre  <= '0;
            r_holes_q <= '0;
            r_tap     <= '0;
            r_hit     <= '0;
            r_miss    <= 1'b0;
            r_score   <= '0;
            for (int i = 0; i < N_HOLE; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sw_pre  <= sw;
            r_holes_q <= holes;
            r_tap     <= w_tap_next;
            r_cnt     <= w_cnt_next;
            r_hit     <= r_tap & r_holes_q & {N_HOLE{en}};
            r_miss    <= en & (|(r_tap & ~r_holes_q));
            r_score   <= w_score_next;
        end
    end

    assign hit   = r_hit;
    assign miss  = r_miss;
    assign score = r_score;
    assign sat   = (r_score == w_all9);

endmodule

// File: tb/tb_wam_score.sv
// Bench for wam_score: two instances (default and N_DIG=2/PENALTY=1) driven
// by directed scenarios then random taps, checked against a timestamp model.
module tb_wam_score;

    localparam int DB = 4;

    logic        clk_19 = 1'b0;
    logic        clr    = 1'b0;
    logic [7:0]  sw     = '0;
    logic [7:0]  holes  = '0;
    logic        en     = 1'b1;
    logic [7:0]  hit0, hit1;
    logic        miss0, miss1, sat0, sat1;
    logic [11:0] score0;
    logic [7:0]  score1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_19 = ~clk_19;

    wam_score #(.N_HOLE(8), .DB_CNT(DB), .N_DIG(3), .PENALTY(0)) u_dut0 (
        .clk_19(clk_19), .clr(clr), .sw(sw), .holes(holes), .en(en),
        .hit(hit0), .miss(miss0), .score(score0), .sat(sat0)
    );

    wam_score #(.N_HOLE(8), .DB_CNT(DB), .N_DIG(2), .PENALTY(1)) u_dut1 (
        .clk_19(clk_19), .clr(clr), .sw(sw), .holes(holes), .en(en),
        .hit(hit1), .miss(miss1), .score(score1), .sat(sat1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Model: each channel remembers the cycle its filter started (-1 = idle).
    int         m_start [8] = '{default: -1};
    int         m_n = 0;
    logic [7:0] m_prev_sw = '0, m_holes_q = '0, m_tap = '0, m_hit = '0;
    logic       m_miss = 1'b0;
    int         m_sc0 = 0, m_sc1 = 0;
    logic [7:0] mv_edg, mv_tap, mv_hit;
    logic       mv_miss;
    int         mv_pop;

    always begin
        @(posedge clk_19 or posedge clr);
        if (clr) begin
            for (int i = 0; i < 8; i++) m_start[i] = -1;
            m_prev_sw = '0; m_holes_q = '0; m_tap = '0; m_hit = '0; m_miss = 1'b0;
            m_sc0 = 0; m_sc1 = 0;
        end else begin
            m_n++;
            mv_edg = sw ^ m_prev_sw;
            mv_tap = '0;
            for (int i = 0; i < 8; i++) begin
                if (m_start[i] < 0) begin
                    if (mv_edg[i]) m_start[i] = m_n;
                end else if (m_n - m_start[i] < DB) begin
                    if (mv_edg[i]) m_start[i] = -1;
                end else begin
                    mv_tap[i]  = 1'b1;
                    m_start[i] = -1;
                end
            end
            mv_hit  = en ? (m_tap & m_holes_q) : 8'h00;
            mv_miss = en && ((m_tap & ~m_holes_q) != 8'h00);
            mv_pop  = $countones(m_hit);
            m_sc0   = (m_sc0 + mv_pop > 999) ? 999 : m_sc0 + mv_pop;
            m_sc1   = m_sc1 + mv_pop - (m_miss ? 1 : 0);
            if (m_sc1 > 99) m_sc1 = 99;
            if (m_sc1 < 0)  m_sc1 = 0;
            m_prev_sw = sw; m_holes_q = holes; m_tap = mv_tap;
            m_hit = mv_hit; m_miss = mv_miss;
        end
    end

    always begin
        @(posedge clk_19);
        #6;
        check("hit0",   32'(hit0),   32'(m_hit));
        check("hit1",   32'(hit1),   32'(m_hit));
        check("miss0",  32'(miss0),  32'(m_miss));
        check("miss1",  32'(miss1),  32'(m_miss));
        check("score0", 32'(score0), 32'(to_bcd(m_sc0)));
        check("score1", 32'(score1), 32'(to_bcd(m_sc1)));
        check("sat0",   32'(sat0),   32'(m_sc0 == 999));
        check("sat1",   32'(sat1),   32'(m_sc1 == 99));
    end

    task automatic edges(input int k);
        repeat (k) @(posedge clk_19);
        #6;
    endtask

    initial begin
        #1 clr = 1'b1;
        edges(2);
        check("rst_hit", 32'(hit0), 32'h0);
        check("rst_miss", 32'(miss0), 32'h0);
        check("rst_score", 32'(score0), 32'h0);
        check("rst_sat", 32'(sat1), 32'h0);
        clr = 1'b0;
        edges(2);
        $display("reset released, score0=%h score1=%h", score0, score1);

        holes = 8'h04; sw[2] = ~sw[2];
        edges(5);
        check("single_hit_early", 32'(hit0), 32'h00);
        edges(1);
        check("single_hit", 32'(hit0), 32'h04);
        check("single_miss", 32'(miss0), 32'h0);
        edges(1);
        check("single_score0", 32'(score0), 32'h001);
        check("single_score1", 32'(score1), 32'h01);
        $display("single tap sw[2]: score0=%h", score0);

        holes = 8'h24; sw[5] = ~sw[5];
        edges(2);
        sw[5] = ~sw[5];
        edges(10);
        check("bounce_score", 32'(score0), 32'h001);
        sw[5] = ~sw[5];
        edges(7);
        check("clean_score", 32'(score0), 32'h002);
        $display("bounce then clean tap sw[5]: score0=%h", score0);

        holes = 8'h81; sw = sw ^ 8'h81;
        edges(6);
        check("simul_hit", 32'(hit0), 32'h81);
        edges(1);
        check("simul_score0", 32'(score0), 32'h004);
        check("simul_score1", 32'(score1), 32'h04);
        holes = 8'h01; sw = sw ^ 8'h81;
        edges(6);
        check("mixed_hit", 32'(hit0), 32'h01);
        check("mixed_miss", 32'(miss1), 32'h1);
        edges(1);
        check("mixed_score0", 32'(score0), 32'h005);
        check("mixed_score1", 32'(score1), 32'h04);
        $display("simultaneous taps: score0=%h score1=%h", score0, score1);

        holes = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            sw[3] = ~sw[3];
            edges(7);
            if (k == 2) check("pen_3to2", 32'(score1), 32'h02);
        end
        check("pen_floor", 32'(score1), 32'h00);
        check("pen_off_score0", 32'(score0), 32'h005);
        $display("miss penalties: score0=%h score1=%h", score0, score1);

        holes = 8'hFF; en = 1'b0; sw = ~sw;
        edges(7);
        check("en_low_score", 32'(score0), 32'h005);
        en = 1'b1;
        edges(10);
        check("en_stale", 32'(score0), 32'h005);

        for (int r = 0; r < 14; r++) begin
            sw = ~sw;
            edges(6);
        end
        edges(2);
        check("sat_score1", 32'(score1), 32'h99);
        check("sat_flag1", 32'(sat1), 32'h1);
        check("carry_score0", 32'(score0), 32'h117);
        check("sat_flag0", 32'(sat0), 32'h0);
        $display("saturation run: score0=%h score1=%h sat1=%b", score0, score1, sat1);

        holes = 8'h02; sw[1] = ~sw[1];
        edges(2);
        @(posedge clk_19);
        #2 clr = 1'b1;
        #1;
        check("clr_score0", 32'(score0), 32'h000);
        check("clr_score1", 32'(score1), 32'h00);
        check("clr_sat", 32'(sat1), 32'h0);
        check("clr_hit", 32'(hit0), 32'h00);
        sw = '0;
        edges(2);
        clr = 1'b0;
        edges(10);
        check("clr_after", 32'(score0), 32'h000);
        $display("clear mid-filter: score0=%h", score0);

        for (int c = 0; c < 3000; c++) begin
            edges(1);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) sw[i] = ~sw[i];
            end
            if ($urandom_range(0, 7) == 0) holes = 8'($urandom);
            en = ($urandom_range(0, 15) != 0);
            #2;
            if (clr) clr = 1'b0;
            else if ($urandom_range(0, 599) == 0) clr = 1'b1;
        end
        clr = 1'b0;
        edges(3);
        $display("random phase done: score0=%h score1=%h", score0, score1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wam_score.md
WAM_SCORE -- requirements
Module: wam_score

Interface
REQ-001 SHALL have parameter N_HOLE, default 8: number of hole/switch channels; legal range 1..9.
REQ-002 SHALL have parameter DB_CNT, default 4: debounce stable-cycle count; legal range 1..15.
REQ-003 SHALL have parameter N_DIG, default 3: number of BCD score digits; legal range 1..4.
REQ-004 SHALL have parameter PENALTY, default 0: 0 means misses do not affect score, 1 means each miss cycle decrements score by 1.
REQ-005 SHALL have port clk_19, input, 1: single system clock; all state is on its rising edge.
REQ-006 SHALL have port clr, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port sw, input, N_HOLE: raw switch levels; any toggle is a tap attempt.
REQ-008 SHALL have port holes, input, N_HOLE: mole-present mask, active high.
REQ-009 SHALL have port en, input, 1: game active; when low, hits/misses are suppressed.
REQ-010 SHALL have port hit, output, N_HOLE: one-cycle pulse per qualified hit.
REQ-011 SHALL have port miss, output, 1: one-cycle pulse when any tap lands on an empty hole.
REQ-012 SHALL have port score, output, 4*N_DIG: packed BCD score, digit 0 in bits [3:0].
REQ-013 SHALL have port sat, output, 1: high while score equals all-9s.

Function
REQ-014 SHALL register sw each cycle (sw_pre); edg[i] = sw[i] XOR sw_pre[i].
REQ-015 SHALL run an independent debounce counter per channel, 4 bits: IDLE (cnt=0) or FILT (cnt 1..DB_CNT).
REQ-016 IDLE: edg[i] -> cnt<=1; tap[i]<=0.
REQ-017 FILT with cnt<DB_CNT: edg[i] -> cnt<=0 (abort, no tap); else cnt<=cnt+1.
REQ-018 FILT with cnt>=DB_CNT: tap[i]<=1 for exactly one cycle, cnt<=0.
REQ-019 Latency: with first edge-detect at clock edge E0 and no further toggle, tap[i] is high between E(DB_CNT) and E(DB_CNT+1).
REQ-020 SHALL register holes once (holes_q); hit <= tap & holes_q & {N_HOLE{en}}, registered, so hit is high between E(DB_CNT+1) and E(DB_CNT+2).
REQ-021 miss <= en & OR(tap & ~holes_q), registered, same timing as hit.
REQ-022 Score SHALL be a synchronous BCD counter clocked by clk_19; no ripple or derived clocks.
REQ-023 Each cycle: delta = popcount(hit) - (PENALTY ? miss : 0), applied at the edge after hit/miss are high (score changes at E(DB_CNT+2)).
REQ-024 BCD addition SHALL propagate decimal carries across all N_DIG digits (e.g. 0x099+1 -> 0x100); no digit ever exceeds 9.
REQ-025 Upper bound: a result above 10^N_DIG-1 SHALL clamp to all-9s; sat=1 combinationally from score.
REQ-026 Lower bound: a result below 0 SHALL clamp to 0.
REQ-027 Simultaneous hit and miss in one cycle: net delta applies (e.g. 2 hits + miss, PENALTY=1 -> +1).
REQ-028 en low: hit=0, miss=0, score held; debounce continues, so no stale tap fires after en rises.

Reset
REQ-029 clr high SHALL immediately clear sw_pre, holes_q, all cnt, tap, hit, miss, and score to 0; sat=0.
REQ-030 clr asserted mid-filter SHALL discard the pending tap; the first edge after release starts fresh.

Verification
REQ-031 Default params, en=1, holes[2]=1, single toggle sw[2] at E0 -> tap[2] high E4-E5, hit=0x04 E5-E6, score=0x001 from E6, miss=0.
REQ-032 Bounce: sw[5] toggles at E0 and back at E2 -> no tap, hit, or score change; clean toggle afterwards -> one hit.
REQ-033 Simultaneous: sw[0], sw[7] toggle same cycle, holes=0x81 -> hit=0x81 one cycle, score +2; holes=0x01 -> hit=0x01, miss=1, score +1 (PENALTY=0) or +0 (PENALTY=1).
REQ-034 Carry/saturation: N_DIG=2, 99 hits -> score=0x99, sat=1; 100th hit -> score stays 0x99; drive 0x09 +1 -> 0x10.
REQ-035 PENALTY=1: score=0 plus miss -> stays 0; score=3 plus miss -> 2.
REQ-036 clr pulse at E2 during filter of sw[1] -> all outputs 0 immediately, no tap after release, score=0.
